// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// state encoding, iteration bounds and operand width.
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_e;

endpackage

// File: rtl/adder_32.sv
// 32-bit adder with carry-in, carry-out and signed overflow flag.
// This is the shared datapath adder reused by multi-cycle execution units.
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);

  logic [32:0] w_full;

  assign w_full   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
  assign sum      = w_full[31:0];
  assign cout     = w_full[32];
  assign overflow = (a[31] == b[31]) && (w_full[31] != a[31]);

endmodule

// File: rtl/mult_32_seq.sv
// Sequential unsigned 32x32 -> 64 shift-add multiplier that reuses a single
// adder_32 over 32 cycles, with a start/ready/busy/done handshake.
module mult_32_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               hi_nz
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_hi_nz;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic                 w_ovf_unused;
  logic [2*WIDTH-1:0]   w_shifted;

  // The multiplier bit at acc_lo[0] selects whether mcand joins the partial sum.
  assign w_addend  = r_acc_lo[0] ? r_mcand : {WIDTH{1'b0}};
  assign w_shifted = {w_cout, w_sum, r_acc_lo[WIDTH-1:1]};

  adder_32 u_adder (
    .a        (r_acc_hi),
    .b        (w_addend),
    .cin      (1'b0),
    .sum      (w_sum),
    .cout     (w_cout),
    .overflow (w_ovf_unused)
  );

  // Next-state logic and handshake decode.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == ITER_LAST) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; status flags are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Operand capture, shift-add iteration and result latch on entry to DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_mcand   <= {WIDTH{1'b0}};
      r_acc_hi  <= {WIDTH{1'b0}};
      r_acc_lo  <= {WIDTH{1'b0}};
      r_product <= {(2*WIDTH){1'b0}};
      r_hi_nz   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mcand  <= op_a;
        r_acc_hi <= {WIDTH{1'b0}};
        r_acc_lo <= op_b;
        r_cnt    <= {CNT_W{1'b0}};
      end else if (r_state == ST_RUN) begin
        {r_acc_hi, r_acc_lo} <= w_shifted;
        r_cnt                <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_last) begin
        r_product <= w_shifted;
        r_hi_nz   <= |w_shifted[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
  assign hi_nz   = r_hi_nz;

endmodule

// File: tb/tb_mult_32_seq.sv
// Directed self-checking bench for mult_32_seq: latency, products, overflow
// flag, ignored starts, back-to-back issue and asynchronous abort.
module tb_mult_32_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        hi_nz;

  int checks;
  int failures;

  mult_32_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product),
    .hi_nz   (hi_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start, step through the accepting edge, drop start.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done (bounded) and how many samples showed busy.
  task automatic wait_done(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op_a = 32'd0; op_b = 32'd0;
    #1;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (product !== 64'd0 || hi_nz !== 1'b0) begin failures++; $display("FAIL reset_product got=%h/%b exp=0/0", product, hi_nz); end
    #12 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int n, bc;
    issue(32'd3, 32'd5);
    checks++; if (ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_accept got=ready%b busy%b exp=ready0 busy1", ready, busy); end
    wait_done(n, bc);
    checks++; if (n !== 32) begin failures++; $display("FAIL basic_latency got=%0d exp=32", n); end
    checks++; if (bc !== 32) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=32", bc); end
    checks++; if (product !== 64'h0000_0000_0000_000F || hi_nz !== 1'b0) begin failures++; $display("FAIL basic_product got=%h/%b exp=%h/0", product, hi_nz, 64'hF); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL basic_done_ready got=%b exp=1", ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (product !== 64'h0000_0000_0000_000F) begin failures++; $display("FAIL basic_hold got=%h exp=%h", product, 64'hF); end
  endtask

  task automatic test_max;
    int n, bc;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, bc);
    checks++; if (product !== 64'hFFFF_FFFE_0000_0001 || hi_nz !== 1'b1) begin failures++; $display("FAIL max_product got=%h/%b exp=%h/1", product, hi_nz, 64'hFFFF_FFFE_0000_0001); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow_zero;
    int n, bc;
    issue(32'h8000_0000, 32'd2);
    wait_done(n, bc);
    checks++; if (product !== 64'h0000_0001_0000_0000 || hi_nz !== 1'b1) begin failures++; $display("FAIL ovf_product got=%h/%b exp=%h/1", product, hi_nz, 64'h1_0000_0000); end
    @(posedge clk); #1;
    issue(32'd0, 32'h1234_5678);
    wait_done(n, bc);
    checks++; if (n !== 32) begin failures++; $display("FAIL zero_latency got=%0d exp=32", n); end
    checks++; if (product !== 64'd0 || hi_nz !== 1'b0) begin failures++; $display("FAIL zero_product got=%h/%b exp=0/0", product, hi_nz); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start;
    int n, bc, extra;
    issue(32'd6, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    op_a = 32'd7; op_b = 32'd7; start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, bc);
    checks++; if (n !== 17) begin failures++; $display("FAIL ignore_latency got=%0d exp=17", n); end
    checks++; if (product !== 64'd54) begin failures++; $display("FAIL ignore_product got=%0d exp=54", product); end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL ignore_no_second_done got=%0d exp=0", extra); end
  endtask

  task automatic test_back_to_back;
    int n, bc;
    op_a = 32'd10; op_b = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    op_a = 32'd11; op_b = 32'd11;
    wait_done(n, bc);
    checks++; if (n !== 32 || product !== 64'd100) begin failures++; $display("FAIL b2b_first got=%0d cyc/%0d exp=32 cyc/100", n, product); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || product !== 64'd100) begin failures++; $display("FAIL b2b_reaccept got=busy%b done%b prod%0d exp=busy1 done0 prod100", busy, done, product); end
    wait_done(n, bc);
    start = 1'b0;
    checks++; if (n !== 32 || product !== 64'd121) begin failures++; $display("FAIL b2b_second got=%0d cyc/%0d exp=32 cyc/121", n, product); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL b2b_idle got=busy%b ready%b exp=busy0 ready1", busy, ready); end
  endtask

  task automatic test_reset_mid_run;
    int n, bc;
    issue(32'd9, 32'd9);
    repeat (14) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_flags got=busy%b ready%b done%b exp=busy0 ready1 done0", busy, ready, done); end
    checks++; if (product !== 64'd0 || hi_nz !== 1'b0) begin failures++; $display("FAIL abort_product got=%h/%b exp=0/0", product, hi_nz); end
    #10 reset = 1'b0;
    @(posedge clk); #1;
    issue(32'd2, 32'd3);
    wait_done(n, bc);
    checks++; if (n !== 32 || product !== 64'd6) begin failures++; $display("FAIL abort_recover got=%0d cyc/%0d exp=32 cyc/6", n, product); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_max();
    test_overflow_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
